// File: rtl/aes_drv_pkg.sv
// Shared types and widths for the aes_core host-side command driver.
package aes_drv_pkg;

    localparam int unsigned AES_BLOCK_W = 128;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        START,
        WAIT,
        CAPTURE,
        RESP
    } drv_state_t;

    typedef enum logic [1:0] {
        ERR_OK      = 2'd0,
        ERR_TIMEOUT = 2'd1,
        ERR_NOKEY   = 2'd2
    } rsp_err_t;

endpackage

// File: rtl/aes_core_driver.sv
// Sequences one aes_core encrypt/decrypt per command and returns the result
// (or an error code) on a valid/ready response stream.
module aes_core_driver
    import aes_drv_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter int unsigned CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic                   cmd_mode,
    input  logic                   cmd_new_key,
    input  logic [AES_BLOCK_W-1:0] cmd_key,
    input  logic [AES_BLOCK_W-1:0] cmd_data,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [AES_BLOCK_W-1:0] rsp_data,
    output logic                   rsp_mode,
    output logic [1:0]             rsp_err,
    output logic                   busy,
    output logic                   core_set_key,
    output logic [AES_BLOCK_W-1:0] core_key,
    output logic                   core_set_plain_text,
    output logic [AES_BLOCK_W-1:0] core_plain_text_in,
    output logic                   core_set_cipher_text,
    output logic [AES_BLOCK_W-1:0] core_cipher_text_in,
    output logic                   core_start_enc,
    output logic                   core_start_dec,
    input  logic                   core_done_enc,
    input  logic                   core_done_dec,
    input  logic [AES_BLOCK_W-1:0] core_cipher_text_out,
    input  logic [AES_BLOCK_W-1:0] core_plain_text_out
);

    drv_state_t             state_q, state_d;
    logic                   mode_q, mode_d;
    logic                   new_key_q, new_key_d;
    logic                   key_loaded_q, key_loaded_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d, cnt_inc;
    logic [AES_BLOCK_W-1:0] key_q, key_d;
    logic [AES_BLOCK_W-1:0] data_q, data_d;
    logic                   cmd_ready_q, cmd_ready_d;
    logic                   rsp_valid_q, rsp_valid_d;
    logic [AES_BLOCK_W-1:0] rsp_data_q, rsp_data_d;
    logic                   rsp_mode_q, rsp_mode_d;
    rsp_err_t               rsp_err_q, rsp_err_d;
    logic                   busy_q, busy_d;
    logic                   set_key_q, set_key_d;
    logic                   set_pt_q, set_pt_d;
    logic                   set_ct_q, set_ct_d;
    logic                   start_enc_q, start_enc_d;
    logic                   start_dec_q, start_dec_d;
    logic                   done_match;

    assign cnt_inc    = cnt_q + CNT_W'(1);
    assign done_match = mode_q ? core_done_dec : core_done_enc;

    // Next-state and registered-output logic; strobes default low so each is one cycle.
    always_comb begin
        state_d      = state_q;
        mode_d       = mode_q;
        new_key_d    = new_key_q;
        key_loaded_d = key_loaded_q;
        cnt_d        = cnt_q;
        key_d        = key_q;
        data_d       = data_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_data_d   = rsp_data_q;
        rsp_mode_d   = rsp_mode_q;
        rsp_err_d    = rsp_err_q;
        set_key_d    = 1'b0;
        set_pt_d     = 1'b0;
        set_ct_d     = 1'b0;
        start_enc_d  = 1'b0;
        start_dec_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    mode_d     = cmd_mode;
                    new_key_d  = cmd_new_key;
                    key_d      = cmd_key;
                    data_d     = cmd_data;
                    rsp_mode_d = cmd_mode;
                    if (!cmd_new_key && !key_loaded_q) begin
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                        rsp_data_d  = '0;
                        rsp_err_d   = ERR_NOKEY;
                    end else begin
                        state_d   = LOAD;
                        set_key_d = cmd_new_key;
                        set_pt_d  = ~cmd_mode;
                        set_ct_d  = cmd_mode;
                    end
                end
            end
            LOAD: begin
                key_loaded_d = key_loaded_q | new_key_q;
                start_enc_d  = ~mode_q;
                start_dec_d  = mode_q;
                state_d      = START;
            end
            START: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                if (done_match) begin
                    state_d = CAPTURE;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == CNT_W'(TIMEOUT_CYCLES)) begin
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                        rsp_data_d  = '0;
                        rsp_err_d   = ERR_TIMEOUT;
                    end
                end
            end
            CAPTURE: begin
                rsp_data_d  = mode_q ? core_plain_text_out : core_cipher_text_out;
                rsp_err_d   = ERR_OK;
                rsp_valid_d = 1'b1;
                state_d     = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        cmd_ready_d = (state_d == IDLE);
        busy_d      = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            mode_q       <= 1'b0;
            new_key_q    <= 1'b0;
            key_loaded_q <= 1'b0;
            cnt_q        <= '0;
            key_q        <= '0;
            data_q       <= '0;
            cmd_ready_q  <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_data_q   <= '0;
            rsp_mode_q   <= 1'b0;
            rsp_err_q    <= ERR_OK;
            busy_q       <= 1'b0;
            set_key_q    <= 1'b0;
            set_pt_q     <= 1'b0;
            set_ct_q     <= 1'b0;
            start_enc_q  <= 1'b0;
            start_dec_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            mode_q       <= mode_d;
            new_key_q    <= new_key_d;
            key_loaded_q <= key_loaded_d;
            cnt_q        <= cnt_d;
            key_q        <= key_d;
            data_q       <= data_d;
            cmd_ready_q  <= cmd_ready_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_data_q   <= rsp_data_d;
            rsp_mode_q   <= rsp_mode_d;
            rsp_err_q    <= rsp_err_d;
            busy_q       <= busy_d;
            set_key_q    <= set_key_d;
            set_pt_q     <= set_pt_d;
            set_ct_q     <= set_ct_d;
            start_enc_q  <= start_enc_d;
            start_dec_q  <= start_dec_d;
        end
    end

    assign cmd_ready            = cmd_ready_q;
    assign rsp_valid            = rsp_valid_q;
    assign rsp_data             = rsp_data_q;
    assign rsp_mode             = rsp_mode_q;
    assign rsp_err              = rsp_err_q;
    assign busy                 = busy_q;
    assign core_set_key         = set_key_q;
    assign core_key             = key_q;
    assign core_set_plain_text  = set_pt_q;
    assign core_plain_text_in   = data_q;
    assign core_set_cipher_text = set_ct_q;
    assign core_cipher_text_in  = data_q;
    assign core_start_enc       = start_enc_q;
    assign core_start_dec       = start_dec_q;

endmodule

// File: tb/tb_aes_core_driver.sv
// Directed bench for aes_core_driver with a behavioural aes_core model and a
// response scoreboard.
module tb_aes_core_driver;
    import aes_drv_pkg::*;

    localparam int unsigned TO       = 8;
    localparam int unsigned CORE_LAT = 4;
    localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic         clk, reset_n;
    logic         cmd_valid, cmd_ready, cmd_mode, cmd_new_key;
    logic [127:0] cmd_key, cmd_data;
    logic         rsp_valid, rsp_ready, rsp_mode;
    logic [127:0] rsp_data;
    logic [1:0]   rsp_err;
    logic         busy;
    logic         core_set_key, core_set_plain_text, core_set_cipher_text;
    logic         core_start_enc, core_start_dec, core_done_enc, core_done_dec;
    logic [127:0] core_key, core_plain_text_in, core_cipher_text_in;
    logic [127:0] core_cipher_text_out, core_plain_text_out;

    aes_core_driver #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_mode(cmd_mode),
        .cmd_new_key(cmd_new_key), .cmd_key(cmd_key), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_mode(rsp_mode), .rsp_err(rsp_err), .busy(busy),
        .core_set_key(core_set_key), .core_key(core_key),
        .core_set_plain_text(core_set_plain_text), .core_plain_text_in(core_plain_text_in),
        .core_set_cipher_text(core_set_cipher_text), .core_cipher_text_in(core_cipher_text_in),
        .core_start_enc(core_start_enc), .core_start_dec(core_start_dec),
        .core_done_enc(core_done_enc), .core_done_dec(core_done_dec),
        .core_cipher_text_out(core_cipher_text_out), .core_plain_text_out(core_plain_text_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [127:0] model_enc(input logic [127:0] k, input logic [127:0] p);
        if (k == K1 && p == P1) return C1;
        return p ^ k ^ {4{32'hdeadbeef}};
    endfunction

    function automatic logic [127:0] model_dec(input logic [127:0] k, input logic [127:0] c);
        if (k == K1 && c == C1) return P1;
        return c ^ k;
    endfunction

    // aes_core model: not tied to reset_n, so a done pending across a driver reset still fires.
    logic [127:0] m_key = '0, m_pt = '0, m_ct = '0, m_ct_out = '0, m_pt_out = '0;
    int           m_cnt = 0;
    logic         m_dec = 1'b0, m_done_enc = 1'b0, m_done_dec = 1'b0;
    logic         core_dead = 1'b0, stray_dec = 1'b0;

    always @(posedge clk) begin
        m_done_enc <= 1'b0;
        m_done_dec <= 1'b0;
        if (core_set_key)         m_key <= core_key;
        if (core_set_plain_text)  m_pt  <= core_plain_text_in;
        if (core_set_cipher_text) m_ct  <= core_cipher_text_in;
        if ((core_start_enc || core_start_dec) && !core_dead) begin
            m_cnt <= int'(CORE_LAT) - 1;
            m_dec <= core_start_dec;
        end else if (m_cnt != 0) begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 1) begin
                if (m_dec) begin
                    m_done_dec <= 1'b1;
                    m_pt_out   <= model_dec(m_key, m_ct);
                end else begin
                    m_done_enc <= 1'b1;
                    m_ct_out   <= model_enc(m_key, m_pt);
                end
            end
        end
    end

    assign core_done_enc        = m_done_enc;
    assign core_done_dec        = m_done_dec | stray_dec;
    assign core_cipher_text_out = m_ct_out;
    assign core_plain_text_out  = m_pt_out;

    // Strobe monitor: counts and the cycle number each strobe was last high.
    int cyc = 0;
    int n_sk = 0, n_sp = 0, n_sc = 0, n_se = 0, n_sd = 0;
    int c_sk = 0, c_sp = 0, c_sc = 0, c_se = 0, c_sd = 0;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (core_set_key)         begin n_sk <= n_sk + 1; c_sk <= cyc; end
        if (core_set_plain_text)  begin n_sp <= n_sp + 1; c_sp <= cyc; end
        if (core_set_cipher_text) begin n_sc <= n_sc + 1; c_sc <= cyc; end
        if (core_start_enc)       begin n_se <= n_se + 1; c_se <= cyc; end
        if (core_start_dec)       begin n_sd <= n_sd + 1; c_sd <= cyc; end
    end

    typedef struct {
        logic [127:0] data;
        logic         mode;
        logic [1:0]   err;
    } exp_t;
    exp_t sb[$];

    int checks = 0, failures = 0;
    int acc_cyc = 0, rsp_cyc = 0;
    int s_sk, s_sp, s_sc, s_se, s_sd;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chkn(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic snap();
        s_sk = n_sk; s_sp = n_sp; s_sc = n_sc; s_se = n_se; s_sd = n_sd;
    endtask

    task automatic send(input logic mode, input logic nk, input logic [127:0] key,
                        input logic [127:0] data, input logic [127:0] exp_data,
                        input logic [1:0] exp_err);
        int n;
        exp_t e;
        cmd_valid = 1'b1; cmd_mode = mode; cmd_new_key = nk; cmd_key = key; cmd_data = data;
        n = 0;
        while (!cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chkn("cmd_ready_seen", int'(cmd_ready), 1);
        acc_cyc = cyc;
        e.data = exp_data; e.mode = mode; e.err = exp_err;
        sb.push_back(e);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic recv(input int stall);
        int   n;
        exp_t e;
        n = 0;
        while (!rsp_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        chkn("rsp_valid_seen", int'(rsp_valid), 1);
        rsp_cyc = cyc;
        if (sb.size() == 0) begin
            chkn("scoreboard_nonempty", 0, 1);
            e.data = '0; e.mode = 1'b0; e.err = 2'd0;
        end else begin
            e = sb.pop_front();
        end
        for (int i = 0; i < stall; i++) begin
            chkn("stall_valid", int'(rsp_valid), 1);
            chk("stall_data", rsp_data, e.data);
            chkn("stall_err", int'(rsp_err), int'(e.err));
            chkn("stall_cmd_ready", int'(cmd_ready), 0);
            @(negedge clk);
        end
        chk("rsp_data", rsp_data, e.data);
        chkn("rsp_mode", int'(rsp_mode), int'(e.mode));
        chkn("rsp_err", int'(rsp_err), int'(e.err));
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chkn("post_rsp_valid", int'(rsp_valid), 0);
        chkn("post_cmd_ready", int'(cmd_ready), 1);
        chkn("post_busy", int'(busy), 0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chkn({tag, "_cmd_ready"}, int'(cmd_ready), 0);
        chkn({tag, "_rsp_valid"}, int'(rsp_valid), 0);
        chkn({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_rsp_data"}, rsp_data, '0);
        chk({tag, "_core_key"}, core_key, '0);
        chk({tag, "_core_text"}, core_plain_text_in, '0);
        chkn({tag, "_strobes"}, int'({core_set_key, core_set_plain_text, core_set_cipher_text,
                                      core_start_enc, core_start_dec}), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic quiet;
        reset_n = 1'b0; cmd_valid = 1'b0; cmd_mode = 1'b0; cmd_new_key = 1'b0;
        cmd_key = '0; cmd_data = '0; rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        reset_n = 1'b1;
        @(negedge clk);

        // First command after reset without a key: immediate error, no core activity.
        snap();
        send(1'b0, 1'b0, K1, P1, '0, 2'd2);
        recv(0);
        chkn("nokey_latency", rsp_cyc - acc_cyc, 1);
        chkn("nokey_strobes", (n_sk - s_sk) + (n_sp - s_sp) + (n_sc - s_sc)
                              + (n_se - s_se) + (n_sd - s_sd), 0);

        // FIPS-197 C.1 encrypt with key load.
        snap();
        send(1'b0, 1'b1, K1, P1, C1, 2'd0);
        recv(0);
        chkn("enc_set_key_cnt", n_sk - s_sk, 1);
        chkn("enc_set_pt_cnt", n_sp - s_sp, 1);
        chkn("enc_set_ct_cnt", n_sc - s_sc, 0);
        chkn("enc_start_enc_cnt", n_se - s_se, 1);
        chkn("enc_start_dec_cnt", n_sd - s_sd, 0);
        chkn("enc_set_same_cycle", c_sk, c_sp);
        chkn("enc_load_cycle", c_sp, acc_cyc + 1);
        chkn("enc_start_after_set", c_se, c_sp + 1);
        chkn("enc_latency", rsp_cyc - acc_cyc, int'(CORE_LAT) + 4);

        // Decrypt reusing the loaded key; cmd_key is garbage and must not be loaded.
        snap();
        send(1'b1, 1'b0, {128{1'b1}}, C1, P1, 2'd0);
        recv(0);
        chkn("dec_set_key_cnt", n_sk - s_sk, 0);
        chkn("dec_set_ct_cnt", n_sc - s_sc, 1);
        chkn("dec_start_dec_cnt", n_sd - s_sd, 1);
        chkn("dec_start_after_set", c_sd, c_sc + 1);

        // Encrypt with a stray done_dec in WAIT and a 10-cycle response stall.
        send(1'b0, 1'b0, '0, P1, C1, 2'd0);
        @(negedge clk);
        @(negedge clk);
        stray_dec = 1'b1;
        @(negedge clk);
        stray_dec = 1'b0;
        recv(10);
        chkn("stray_latency", rsp_cyc - acc_cyc, int'(CORE_LAT) + 4);

        // Core never finishes: timeout after exactly TO WAIT cycles.
        core_dead = 1'b1;
        send(1'b0, 1'b0, '0, P1, '0, 2'd1);
        recv(0);
        chkn("timeout_latency", rsp_cyc - acc_cyc, int'(TO) + 3);
        core_dead = 1'b0;

        // Reset in WAIT: outputs clear, the in-flight done is ignored, no response.
        send(1'b0, 1'b1, K1, P1, C1, 2'd0);
        repeat (3) @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk_reset_outputs("midreset");
        sb.delete();
        @(negedge clk);
        reset_n = 1'b1;
        quiet = 1'b1;
        repeat (8) begin
            @(negedge clk);
            if (rsp_valid || busy) quiet = 1'b0;
        end
        chkn("post_reset_quiet", int'(quiet), 1);

        // key_loaded must have been cleared by the reset.
        send(1'b0, 1'b0, K1, P1, '0, 2'd2);
        recv(0);

        send(1'b0, 1'b1, K1, P1, C1, 2'd0);
        recv(0);
        chkn("sb_drained", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/aes_core_driver.md
Name: aes_core_driver

Overview:
Host-side initiator for aes_core: accepts one 128-bit encrypt/decrypt command at a time over a valid/ready stream and sequences the core's set_key / set_*_text / start_* / done_* register protocol. Returns the result (or an error code) on a valid/ready response stream. Sits between the system bus adapter and aes_core; this is the only block that drives aes_core's control inputs.

Parameters:
TIMEOUT_CYCLES, 64, max cycles in WAIT before aborting with a timeout error (must be >= 2)
CNT_W, $clog2(TIMEOUT_CYCLES+1), width of the timeout counter

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  driver accepts the command this cycle
cmd_mode  in  1  0 = encrypt, 1 = decrypt
cmd_new_key  in  1  load cmd_key before the operation
cmd_key  in  128  key, used only when cmd_new_key=1
cmd_data  in  128  plaintext (enc) or ciphertext (dec)
rsp_valid  out  1  response present
rsp_ready  in  1  consumer takes the response
rsp_data  out  128  result block
rsp_mode  out  1  echo of cmd_mode
rsp_err  out  2  0 = OK, 1 = timeout, 2 = no key loaded
busy  out  1  high in every state except IDLE
core_set_key  out  1  to aes_core set_key
core_key  out  128  to aes_core key
core_set_plain_text  out  1  to aes_core set_plain_text
core_plain_text_in  out  128  to aes_core plain_text_in
core_set_cipher_text  out  1  to aes_core set_cipher_text
core_cipher_text_in  out  128  to aes_core cipher_text_in
core_start_enc  out  1  to aes_core start_enc
core_start_dec  out  1  to aes_core start_dec
core_done_enc  in  1  from aes_core done_enc
core_done_dec  in  1  from aes_core done_dec
core_cipher_text_out  in  128  from aes_core cipher_text_out
core_plain_text_out  in  128  from aes_core plain_text_out

Behaviour:
- Reset (async, active-low): state = IDLE, all outputs 0, key_loaded = 0, counter = 0. Reset mid-operation aborts with no response; any pending core done is ignored afterwards.
- All core_* control strobes are registered single-cycle pulses. core_key and core_*_text_in are registered copies of the command and held stable until the next accept.
- IDLE: cmd_ready = 1. On cmd_valid, latch mode, new_key, key and data.
  - If new_key = 0 and key_loaded = 0, go to RESP with rsp_err = 2 and rsp_data = 0.
  - Otherwise go to LOAD.
- LOAD (1 cycle):
  - Pulse core_set_key if new_key = 1, and set key_loaded.
  - Pulse core_set_plain_text (enc) or core_set_cipher_text (dec).
  - Go to START.
- START (1 cycle): pulse core_start_enc or core_start_dec per mode, clear the counter, go to WAIT. The start pulse is always exactly one cycle after the set pulses, so the core's key and text registers are already loaded.
- WAIT:
  - Sample only the done matching the mode; the opposite done is ignored.
  - On the matching done, go to CAPTURE.
  - Otherwise increment the counter. When the counter reaches TIMEOUT_CYCLES, go to RESP with rsp_err = 1 and rsp_data = 0.
- CAPTURE (1 cycle): the core's output register updates on the done edge, so read it here. rsp_data = core_cipher_text_out (enc) or core_plain_text_out (dec), rsp_err = 0. Go to RESP.
- RESP:
  - rsp_valid = 1; rsp_data, rsp_mode and rsp_err are stable while valid.
  - On rsp_ready, go to IDLE. The earliest next cmd_ready is the following cycle, so there is no same-cycle accept/respond bypass.
- Latency, accept to rsp_valid, OK path: core compute latency + 4 cycles (LOAD, START, done cycle, CAPTURE).
- A done arriving in IDLE, LOAD, START, CAPTURE or RESP is ignored.
- Key persists across commands until reset. Decrypt after an encrypt with the same key needs no reload.

Decomposition:
- Package aes_drv_pkg:
  - typedef enum drv_state_t {IDLE, LOAD, START, WAIT, CAPTURE, RESP}
  - typedef enum rsp_err_t {ERR_OK = 0, ERR_TIMEOUT = 1, ERR_NOKEY = 2}
  - localparam AES_BLOCK_W = 128
- Single module, no sub-module. FSM, timeout counter and the command/response holding registers fit flat.

Test Plan:
- FIPS-197 C.1 encrypt: new_key = 1, key 000102030405060708090a0b0c0d0e0f, data 00112233445566778899aabbccddeeff -> rsp_data 69c4e0d86a7b0430d8cdb78070b4c55a, err 0, mode 0. Check set_key and set_plain_text occur in the same cycle, and start_enc is exactly one cycle later.
- Decrypt with new_key = 0 after the previous test, data 69c4e0d86a7b0430d8cdb78070b4c55a -> rsp_data 00112233445566778899aabbccddeeff, err 0. Check no set_key pulse.
- After reset, first command has new_key = 0 -> rsp_valid within 2 cycles of accept, err 2, data 0, and no core_* strobe at all.
- Core model that never asserts done, TIMEOUT_CYCLES = 8 -> err 1, data 0 after exactly 8 WAIT cycles, then the driver returns to IDLE.
- Hold rsp_ready = 0 for 10 cycles, and inject a stray done_dec during an encrypt -> rsp held stable with cmd_ready = 0 throughout, and the stray done has no effect.
- Assert reset_n = 0 in WAIT, then release and issue a new C.1 encrypt with new_key = 1 -> outputs 0 during reset, no stale response, correct ciphertext returned.
